// File: rtl/req_arbiter8.sv
// Eight-way request arbiter: fixed-priority or round-robin grant with hold limit.
// Registered one-hot grant plus encoded index; one idle bubble between owners.
module req_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       mode,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout_pulse
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_nx;
    logic [HOLD_W-1:0] hold, hold_nx;
    logic [2:0]        last_idx, last_nx;
    logic [7:0]        grant_nx;
    logic [2:0]        idx_nx;
    logic              valid_nx;
    logic              to_nx;

    logic [2:0] fix_idx;
    logic [2:0] rr_idx;
    logic [2:0] cand;
    logic [2:0] win_idx;
    logic       owner_req;
    logic       timed_out;

    always_comb begin
        fix_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) fix_idx = 3'(i);
        end
    end

    // Scan down so the nearest index after last_idx is the final writer.
    always_comb begin
        rr_idx = 3'd0;
        cand   = 3'd0;
        for (int k = 8; k >= 1; k--) begin
            cand = last_idx + 3'(k);
            if (req[cand]) rr_idx = cand;
        end
    end

    assign win_idx   = mode ? rr_idx : fix_idx;
    assign owner_req = req[grant_idx];
    assign timed_out = (MAX_HOLD != 0) && (hold == HOLD_W'(MAX_HOLD));

    always_comb begin
        state_nx = state;
        hold_nx  = hold;
        last_nx  = last_idx;
        grant_nx = grant;
        idx_nx   = grant_idx;
        valid_nx = grant_valid;
        to_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                grant_nx = 8'd0;
                idx_nx   = 3'd0;
                valid_nx = 1'b0;
                hold_nx  = '0;
                if (enable && (req != 8'd0)) begin
                    state_nx = BUSY;
                    grant_nx = 8'd1 << win_idx;
                    idx_nx   = win_idx;
                    valid_nx = 1'b1;
                    hold_nx  = HOLD_W'(1);
                    last_nx  = win_idx;
                end
            end
            BUSY: begin
                if (!enable || !owner_req || timed_out) begin
                    state_nx = IDLE;
                    grant_nx = 8'd0;
                    idx_nx   = 3'd0;
                    valid_nx = 1'b0;
                    hold_nx  = '0;
                    to_nx    = enable && owner_req;
                end else if (hold != {HOLD_W{1'b1}}) begin
                    hold_nx = hold + HOLD_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            hold          <= '0;
            last_idx      <= 3'd7;
            grant         <= 8'd0;
            grant_idx     <= 3'd0;
            grant_valid   <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_nx;
            hold          <= hold_nx;
            last_idx      <= last_nx;
            grant         <= grant_nx;
            grant_idx     <= idx_nx;
            grant_valid   <= valid_nx;
            timeout_pulse <= to_nx;
        end
    end

endmodule

// File: tb/tb_req_arbiter8.sv
// Directed bench for req_arbiter8 with a 4-cycle hold limit.
// Expected values are hand-derived per cycle.
module tb_req_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       mode = 1'b0;
    logic [7:0] req = 8'hFF;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout_pulse;

    int total = 0;
    int bad   = 0;

    req_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .mode         (mode),
        .req          (req),
        .grant        (grant),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] g,
                              input logic [2:0] idx, input logic v,
                              input logic to);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".idx"}, 32'(grant_idx), 32'(idx));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(v));
        chk({tag, ".to"}, 32'(timeout_pulse), 32'(to));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, then grant, then async reset mid-grant.
        #1;
        expect_out("rst0", 8'h00, 3'd0, 1'b0, 1'b0);
        #3 rst_n = 1'b1;
        step();
        expect_out("rst_g1", 8'h80, 3'd7, 1'b1, 1'b0);
        step();
        step();
        expect_out("rst_g3", 8'h80, 3'd7, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        expect_out("rst_async", 8'h00, 3'd0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        step();
        expect_out("rst_after", 8'h80, 3'd7, 1'b1, 1'b0);
        req = 8'h00;
        step();
        expect_out("rst_rel", 8'h00, 3'd0, 1'b0, 1'b0);

        // Fixed priority.
        req = 8'b0010_0110;
        step();
        expect_out("fix_a", 8'h20, 3'd5, 1'b1, 1'b0);
        req = 8'b0000_0100;
        step();
        expect_out("fix_bub", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        expect_out("fix_b", 8'h04, 3'd2, 1'b1, 1'b0);
        req = 8'h00;
        step();

        // Round-robin rotation 0..7,0.
        do_reset();
        mode = 1'b1;
        req  = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            logic [2:0] e;
            e = 3'(k % 8);
            step();
            expect_out($sformatf("rr%0d_a", k), 8'd1 << e, e, 1'b1, 1'b0);
            step();
            expect_out($sformatf("rr%0d_b", k), 8'd1 << e, e, 1'b1, 1'b0);
            req = 8'hFF & ~(8'd1 << e);
            step();
            expect_out($sformatf("rr%0d_bub", k), 8'h00, 3'd0, 1'b0, 1'b0);
            req = 8'hFF;
        end
        req = 8'h00;
        step();

        // Hold-limit timeout with round-robin.
        do_reset();
        mode = 1'b1;
        req  = 8'h09;
        for (int c = 0; c < 4; c++) begin
            step();
            expect_out($sformatf("to0_c%0d", c), 8'h01, 3'd0, 1'b1, 1'b0);
        end
        step();
        expect_out("to0_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step();
            expect_out($sformatf("to3_c%0d", c), 8'h08, 3'd3, 1'b1, 1'b0);
        end
        step();
        expect_out("to3_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
        step();
        expect_out("to_back0", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h00;
        step();

        // Enable drop: forced release, no pulse, no new grant.
        do_reset();
        mode = 1'b0;
        req  = 8'h10;
        step();
        expect_out("en_g", 8'h10, 3'd4, 1'b1, 1'b0);
        enable = 1'b0;
        step();
        expect_out("en_off1", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        expect_out("en_off2", 8'h00, 3'd0, 1'b0, 1'b0);
        enable = 1'b1;
        req    = 8'h00;
        step();
        expect_out("en_on_noreq", 8'h00, 3'd0, 1'b0, 1'b0);

        // Non-owner traffic ignored during a grant.
        req = 8'h02;
        step();
        expect_out("own_g", 8'h02, 3'd1, 1'b1, 1'b0);
        req = 8'h82;
        step();
        expect_out("own_h1", 8'h02, 3'd1, 1'b1, 1'b0);
        step();
        expect_out("own_h2", 8'h02, 3'd1, 1'b1, 1'b0);
        req = 8'h80;
        step();
        expect_out("own_bub", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        expect_out("own_7", 8'h80, 3'd7, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
